dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: configurable-latency word array with
// byte/half lane handling, load sign-extension and alignment checking. Optional Err_Count port: DMEM_ERRCNT_EN.
module dmem_responder #(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        R_Enable,
  input  logic        W_Enable,
  input  logic [1:0]  R_Width,
  input  logic [1:0]  W_Width,
  input  logic [31:0] Address,
  input  logic [31:0] W_Data,
  output logic [31:0] R_Data,
  output logic        Stall,
  output logic        Done,
  output logic        Misaligned
`ifdef DMEM_ERRCNT_EN
  ,
  output logic [15:0] Err_Count
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        run_q;
  logic [31:0] rdata_q;
  logic        mis_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  rw_q, ww_q;
  logic        wr_q;
  logic [31:0] mem [DEPTH];

  logic                 req, in_idle, commit, err, wr_e;
  logic [31:0]          a_e, wd_e, word, shifted, mask, ld_val, merged;
  logic [1:0]           rw_e, ww_e, width;
  logic [4:0]           sh;
  logic [ADDR_BITS-1:0] idx;
  logic                 unused_addr_bits;

  assign req     = R_Enable | W_Enable;
  assign in_idle = (state_q == IDLE);

  // With LATENCY=1 the commit edge is also the acceptance edge, so the live inputs are used then.
  assign a_e   = in_idle ? Address  : addr_q;
  assign wd_e  = in_idle ? W_Data   : wdata_q;
  assign rw_e  = in_idle ? R_Width  : rw_q;
  assign ww_e  = in_idle ? W_Width  : ww_q;
  assign wr_e  = in_idle ? W_Enable : wr_q;
  assign width = wr_e ? ww_e : rw_e;
  assign err   = (width == 2'b11) || (width == 2'b01 && a_e[0]) || (width == 2'b00 && a_e[1:0] != 2'b00);
  assign idx   = a_e[ADDR_BITS+1:2];
  assign unused_addr_bits = ^a_e[31:ADDR_BITS+2];
  assign word    = mem[idx];
  assign sh      = {a_e[1:0], 3'b000};
  assign shifted = word >> sh;

  always_comb begin
    mask   = 32'hFFFF_FFFF;
    ld_val = word;
    case (width)
      2'b01: begin
        mask   = 32'h0000_FFFF << sh;
        ld_val = {{16{shifted[15]}}, shifted[15:0]};
      end
      2'b10: begin
        mask   = 32'h0000_00FF << sh;
        ld_val = {{24{shifted[7]}}, shifted[7:0]};
      end
      default: ;
    endcase
  end

  assign merged = (word & ~mask) | ((wd_e << sh) & mask);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: if (req && run_q) begin
        cnt_d = 4'(LATENCY - 1);
        if (LATENCY == 1) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // run_q keeps a request held during reset from committing on the first edge after release.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      run_q   <= 1'b0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= 1'b1;
      mis_q   <= commit && err;
      if (commit && !wr_e && !err) rdata_q <= ld_val;
    end
  end

  always_ff @(posedge Clock) begin
    if (in_idle && req) begin
      addr_q  <= Address;
      wdata_q <= W_Data;
      rw_q    <= R_Width;
      ww_q    <= W_Width;
      wr_q    <= W_Enable;
    end
  end

  always_ff @(posedge Clock) begin
    if (commit && wr_e && !err) mem[idx] <= merged;
  end

`ifdef DMEM_ERRCNT_EN
  logic [15:0] errcnt_q;
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) errcnt_q <= 16'd0;
    else if (commit && err && errcnt_q != 16'hFFFF) errcnt_q <= errcnt_q + 16'd1;
  end
  assign Err_Count = errcnt_q;
`endif

  assign R_Data     = rdata_q;
  assign Done       = (state_q == RESP);
  assign Misaligned = mis_q;
  assign Stall      = (in_idle && req) || (state_q == BUSY);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 4, 1) checked against a
// word-array reference model of the load/store/alignment rules.
module tb_dmem_responder;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        re [3];
  logic        we [3];
  logic [1:0]  rw [3];
  logic [1:0]  ww [3];
  logic [31:0] ad [3];
  logic [31:0] wd [3];
  logic [31:0] rd [3];
  logic        st [3];
  logic        dn [3];
  logic        ms [3];
`ifdef DMEM_ERRCNT_EN
  logic [15:0] ec [3];
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] mdl [3][1024];
  logic [31:0] last_rd [3];
  int          errexp [3];

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    int          lat;
    int          stall;
    logic        sdone;
    logic        pulse;
    int          dcyc;
  } obs_t;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(1024), .ADDR_BITS(10), .LATENCY(2)) u_l2 (
    .Clock(Clock), .Reset_n(Reset_n), .R_Enable(re[0]), .W_Enable(we[0]),
    .R_Width(rw[0]), .W_Width(ww[0]), .Address(ad[0]), .W_Data(wd[0]),
    .R_Data(rd[0]), .Stall(st[0]), .Done(dn[0]), .Misaligned(ms[0])
`ifdef DMEM_ERRCNT_EN
    , .Err_Count(ec[0])
`endif
  );

  dmem_responder #(.DEPTH(1024), .ADDR_BITS(10), .LATENCY(4)) u_l4 (
    .Clock(Clock), .Reset_n(Reset_n), .R_Enable(re[1]), .W_Enable(we[1]),
    .R_Width(rw[1]), .W_Width(ww[1]), .Address(ad[1]), .W_Data(wd[1]),
    .R_Data(rd[1]), .Stall(st[1]), .Done(dn[1]), .Misaligned(ms[1])
`ifdef DMEM_ERRCNT_EN
    , .Err_Count(ec[1])
`endif
  );

  dmem_responder #(.DEPTH(1024), .ADDR_BITS(10), .LATENCY(1)) u_l1 (
    .Clock(Clock), .Reset_n(Reset_n), .R_Enable(re[2]), .W_Enable(we[2]),
    .R_Width(rw[2]), .W_Width(ww[2]), .Address(ad[2]), .W_Data(wd[2]),
    .R_Data(rd[2]), .Stall(st[2]), .Done(dn[2]), .Misaligned(ms[2])
`ifdef DMEM_ERRCNT_EN
    , .Err_Count(ec[2])
`endif
  );

  // Reference: lanes by shift amount 8*addr[1:0]; index = (addr/4) mod 1024.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] wdt, input logic [31:0] a);
    logic [31:0] v;
    v = w >> (8 * a[1:0]);
    if (wdt == 2'd1) begin
      v = v & 32'hFFFF;
      if (v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else if (wdt == 2'd2) begin
      v = v & 32'hFF;
      if (v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic void model(input int k, input logic r, input logic w, input logic [1:0] rwd,
                                input logic [1:0] wwd, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] erd, output logic emis);
    logic [1:0]  wdt;
    logic [31:0] m;
    int          idx;
    wdt  = w ? wwd : rwd;
    emis = (wdt == 2'd3) || (wdt == 2'd1 && a[0]) || (wdt == 2'd0 && (a % 4) != 0);
    idx  = int'((a / 4) % 1024);
    if (emis) begin
      errexp[k]++;
    end else if (w) begin
      m = (wdt == 2'd2) ? 32'hFF : (wdt == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      m = m << (8 * a[1:0]);
      mdl[k][idx] = (mdl[k][idx] & ~m) | ((d << (8 * a[1:0])) & m);
    end else if (r) begin
      last_rd[k] = ref_load(mdl[k][idx], wdt, a);
    end
    erd = last_rd[k];
  endfunction

  // Called at posedge+1 with the instance idle; returns at posedge+1 with it idle again.
  task automatic access(input int k, input logic r, input logic w, input logic [1:0] rwd,
                        input logic [1:0] wwd, input logic [31:0] a, input logic [31:0] d,
                        output obs_t o);
    re[k] = r; we[k] = w; rw[k] = rwd; ww[k] = wwd; ad[k] = a; wd[k] = d;
    o.lat = 0;
    o.stall = 0;
    #1;
    if (st[k]) o.stall++;
    do begin
      @(posedge Clock); #1;
      o.lat++;
      if (st[k] && !dn[k]) o.stall++;
    end while (!dn[k] && o.lat < 40);
    o.sdone = st[k];
    o.rd    = rd[k];
    o.mis   = ms[k];
    o.dcyc  = cyc;
    re[k] = 1'b0; we[k] = 1'b0;
    @(posedge Clock); #1;
    o.pulse = dn[k];
  endtask

  task automatic test_reset;
    for (int k = 0; k < 3; k++) begin
      checks++; if (rd[k] !== 32'd0) begin errors++; $display("FAIL reset_rdata[%0d]: got %h want 0", k, rd[k]); end
      checks++; if (st[k] !== 1'b0) begin errors++; $display("FAIL reset_stall[%0d]: got %b want 0", k, st[k]); end
      checks++; if (dn[k] !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b want 0", k, dn[k]); end
      checks++; if (ms[k] !== 1'b0) begin errors++; $display("FAIL reset_mis[%0d]: got %b want 0", k, ms[k]); end
`ifdef DMEM_ERRCNT_EN
      checks++; if (ec[k] !== 16'd0) begin errors++; $display("FAIL reset_errcnt[%0d]: got %0d want 0", k, ec[k]); end
`endif
    end
  endtask

  task automatic test_word_roundtrip;
    obs_t o; logic [31:0] erd; logic em;
    model(0, 1'b0, 1'b1, 2'd0, 2'd0, 32'h10, 32'hDEADBEEF, erd, em);
    access(0, 1'b0, 1'b1, 2'd0, 2'd0, 32'h10, 32'hDEADBEEF, o);
    checks++; if (o.lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", o.lat); end
    checks++; if (o.stall !== 2) begin errors++; $display("FAIL sw_stall_cycles: got %0d want 2", o.stall); end
    checks++; if (o.mis !== 1'b0) begin errors++; $display("FAIL sw_mis: got %b want 0", o.mis); end
    checks++; if (o.pulse !== 1'b0) begin errors++; $display("FAIL sw_done_width: got %b want 0", o.pulse); end
    model(0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h10, 32'h0, erd, em);
    access(0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h10, 32'h0, o);
    checks++; if (o.rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h want deadbeef", o.rd); end
    checks++; if (o.lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", o.lat); end
    checks++; if (o.stall !== 2) begin errors++; $display("FAIL lw_stall_cycles: got %0d want 2", o.stall); end
    checks++; if (o.sdone !== 1'b0) begin errors++; $display("FAIL lw_stall_in_done: got %b want 0", o.sdone); end
  endtask

  task automatic test_lanes;
    obs_t o; logic [31:0] erd; logic em;
    model(0, 1'b0, 1'b1, 2'd0, 2'd0, 32'h20, 32'h11223344, erd, em);
    access(0, 1'b0, 1'b1, 2'd0, 2'd0, 32'h20, 32'h11223344, o);
    model(0, 1'b0, 1'b1, 2'd0, 2'd2, 32'h21, 32'h00000080, erd, em);
    access(0, 1'b0, 1'b1, 2'd0, 2'd2, 32'h21, 32'h00000080, o);
    checks++; if (o.mis !== 1'b0) begin errors++; $display("FAIL sb_mis: got %b want 0", o.mis); end
    access(0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h20, 32'h0, o);
    model(0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h20, 32'h0, erd, em);
    checks++; if (o.rd !== 32'h11228044) begin errors++; $display("FAIL lanes_word: got %h want 11228044", o.rd); end
    access(0, 1'b1, 1'b0, 2'd2, 2'd0, 32'h21, 32'h0, o);
    model(0, 1'b1, 1'b0, 2'd2, 2'd0, 32'h21, 32'h0, erd, em);
    checks++; if (o.rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signext: got %h want ffffff80", o.rd); end
    access(0, 1'b1, 1'b0, 2'd1, 2'd0, 32'h22, 32'h0, o);
    model(0, 1'b1, 1'b0, 2'd1, 2'd0, 32'h22, 32'h0, erd, em);
    checks++; if (o.rd !== 32'h00001122) begin errors++; $display("FAIL lh_upper: got %h want 00001122", o.rd); end
  endtask

  task automatic test_misaligned;
    obs_t o; logic [31:0] erd; logic em;
    model(0, 1'b0, 1'b1, 2'd0, 2'd0, 32'h08, 32'h01020304, erd, em);
    access(0, 1'b0, 1'b1, 2'd0, 2'd0, 32'h08, 32'h01020304, o);
    model(0, 1'b0, 1'b1, 2'd0, 2'd0, 32'h0A, 32'hCAFEF00D, erd, em);
    access(0, 1'b0, 1'b1, 2'd0, 2'd0, 32'h0A, 32'hCAFEF00D, o);
    checks++; if (o.mis !== 1'b1) begin errors++; $display("FAIL sw_misaligned: got %b want 1", o.mis); end
    checks++; if (o.pulse !== 1'b0) begin errors++; $display("FAIL mis_done_width: got %b want 0", o.pulse); end
    checks++; if (ms[0] !== 1'b0) begin errors++; $display("FAIL mis_pulse_width: got %b want 0", ms[0]); end
    access(0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h08, 32'h0, o);
    model(0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h08, 32'h0, erd, em);
    checks++; if (o.rd !== 32'h01020304) begin errors++; $display("FAIL mis_no_write: got %h want 01020304", o.rd); end
    access(0, 1'b1, 1'b0, 2'd1, 2'd0, 32'h03, 32'h0, o);
    model(0, 1'b1, 1'b0, 2'd1, 2'd0, 32'h03, 32'h0, erd, em);
    checks++; if (o.mis !== 1'b1) begin errors++; $display("FAIL lh_misaligned: got %b want 1", o.mis); end
    checks++; if (o.rd !== 32'h01020304) begin errors++; $display("FAIL lh_mis_hold: got %h want 01020304", o.rd); end
    access(0, 1'b1, 1'b0, 2'd3, 2'd0, 32'h08, 32'h0, o);
    model(0, 1'b1, 1'b0, 2'd3, 2'd0, 32'h08, 32'h0, erd, em);
    checks++; if (o.mis !== 1'b1) begin errors++; $display("FAIL width11_mis: got %b want 1", o.mis); end
`ifdef DMEM_ERRCNT_EN
    checks++; if (ec[0] !== 16'd3) begin errors++; $display("FAIL err_count: got %0d want 3", ec[0]); end
`endif
  endtask

  task automatic test_reset_mid;
    obs_t o; logic [31:0] erd; logic em; logic seen;
    model(1, 1'b0, 1'b1, 2'd0, 2'd0, 32'h40, 32'hAAAA5555, erd, em);
    access(1, 1'b0, 1'b1, 2'd0, 2'd0, 32'h40, 32'hAAAA5555, o);
    checks++; if (o.lat !== 4) begin errors++; $display("FAIL l4_latency: got %0d want 4", o.lat); end
    access(1, 1'b1, 1'b0, 2'd0, 2'd0, 32'h40, 32'h0, o);
    model(1, 1'b1, 1'b0, 2'd0, 2'd0, 32'h40, 32'h0, erd, em);
    checks++; if (o.stall !== 4) begin errors++; $display("FAIL l4_stall_cycles: got %0d want 4", o.stall); end
    re[1] = 1'b0; we[1] = 1'b1; rw[1] = 2'd0; ww[1] = 2'd0; ad[1] = 32'h40; wd[1] = 32'h12345678;
    seen = 1'b0;
    @(posedge Clock); #1; seen |= dn[1];
    @(posedge Clock); #1; seen |= dn[1];
    checks++; if (st[1] !== 1'b1) begin errors++; $display("FAIL busy_stall: got %b want 1", st[1]); end
    Reset_n = 1'b0; we[1] = 1'b0;
    #1;
    checks++; if (rd[1] !== 32'd0) begin errors++; $display("FAIL midrst_rdata: got %h want 0", rd[1]); end
    checks++; if (st[1] !== 1'b0 || ms[1] !== 1'b0 || dn[1] !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl: got stall=%b mis=%b done=%b want 0", st[1], ms[1], dn[1]);
    end
    repeat (3) begin @(posedge Clock); #1; seen |= dn[1]; end
    Reset_n = 1'b1;
    repeat (3) begin @(posedge Clock); #1; seen |= dn[1]; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", seen); end
    for (int k = 0; k < 3; k++) begin last_rd[k] = 32'd0; errexp[k] = 0; end
    access(1, 1'b1, 1'b0, 2'd0, 2'd0, 32'h40, 32'h0, o);
    model(1, 1'b1, 1'b0, 2'd0, 2'd0, 32'h40, 32'h0, erd, em);
    checks++; if (o.rd !== 32'hAAAA5555) begin errors++; $display("FAIL midrst_no_store: got %h want aaaa5555", o.rd); end
  endtask

  task automatic test_wrap_simul;
    obs_t o; logic [31:0] erd; logic em;
    model(0, 1'b0, 1'b1, 2'd0, 2'd0, 32'h1004, 32'h5A5A1234, erd, em);
    access(0, 1'b0, 1'b1, 2'd0, 2'd0, 32'h1004, 32'h5A5A1234, o);
    access(0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h4, 32'h0, o);
    model(0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h4, 32'h0, erd, em);
    checks++; if (o.rd !== 32'h5A5A1234) begin errors++; $display("FAIL addr_wrap: got %h want 5a5a1234", o.rd); end
    model(0, 1'b1, 1'b1, 2'd0, 2'd0, 32'h30, 32'h77665544, erd, em);
    access(0, 1'b1, 1'b1, 2'd0, 2'd0, 32'h30, 32'h77665544, o);
    checks++; if (o.rd !== 32'h5A5A1234) begin errors++; $display("FAIL simul_rdata_hold: got %h want 5a5a1234", o.rd); end
    checks++; if (o.mis !== 1'b0) begin errors++; $display("FAIL simul_mis: got %b want 0", o.mis); end
    access(0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h30, 32'h0, o);
    model(0, 1'b1, 1'b0, 2'd0, 2'd0, 32'h30, 32'h0, erd, em);
    checks++; if (o.rd !== 32'h77665544) begin errors++; $display("FAIL simul_store: got %h want 77665544", o.rd); end
  endtask

  task automatic test_back_to_back;
    obs_t o1, o2; logic [31:0] erd; logic em;
    model(2, 1'b0, 1'b1, 2'd0, 2'd0, 32'h0, 32'hA1B2C3D4, erd, em);
    access(2, 1'b0, 1'b1, 2'd0, 2'd0, 32'h0, 32'hA1B2C3D4, o1);
    model(2, 1'b0, 1'b1, 2'd0, 2'd0, 32'h4, 32'h0BADF00D, erd, em);
    access(2, 1'b0, 1'b1, 2'd0, 2'd0, 32'h4, 32'h0BADF00D, o1);
    access(2, 1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, o1);
    access(2, 1'b1, 1'b0, 2'd1, 2'd0, 32'h6, 32'h0, o2);
    checks++; if (o1.lat !== 1 || o2.lat !== 1) begin errors++; $display("FAIL l1_latency: got %0d,%0d want 1,1", o1.lat, o2.lat); end
    checks++; if (o2.dcyc - o1.dcyc !== 2) begin errors++; $display("FAIL b2b_spacing: got %0d want 2", o2.dcyc - o1.dcyc); end
    checks++; if (o1.sdone !== 1'b0 || o2.sdone !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_done: got %b,%b want 0,0", o1.sdone, o2.sdone); end
    checks++; if (o1.rd !== 32'hA1B2C3D4) begin errors++; $display("FAIL b2b_first: got %h want a1b2c3d4", o1.rd); end
    checks++; if (o2.rd !== 32'h00000BAD) begin errors++; $display("FAIL b2b_second: got %h want 00000bad", o2.rd); end
  endtask

  task automatic test_random;
    obs_t o; logic [31:0] erd, a, d; logic em, r, w; logic [1:0] rwd, wwd;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      model(0, 1'b0, 1'b1, 2'd0, 2'd0, 32'(i * 4), d, erd, em);
      access(0, 1'b0, 1'b1, 2'd0, 2'd0, 32'(i * 4), d, o);
    end
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: begin r = 1'b1; w = 1'b1; end
        1: begin r = 1'b0; w = 1'b1; end
        default: begin r = 1'b1; w = 1'b0; end
      endcase
      rwd = 2'($urandom_range(0, 3));
      wwd = 2'($urandom_range(0, 3));
      a   = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      d   = $urandom;
      model(0, r, w, rwd, wwd, a, d, erd, em);
      access(0, r, w, rwd, wwd, a, d, o);
      checks++; if (o.rd !== erd) begin errors++; $display("FAIL rand_rdata #%0d a=%h: got %h want %h", i, a, o.rd, erd); end
      checks++; if (o.mis !== em) begin errors++; $display("FAIL rand_mis #%0d a=%h: got %b want %b", i, a, o.mis, em); end
      checks++; if (o.lat !== 2) begin errors++; $display("FAIL rand_latency #%0d: got %0d want 2", i, o.lat); end
    end
`ifdef DMEM_ERRCNT_EN
    checks++; if (ec[0] !== 16'(errexp[0])) begin errors++; $display("FAIL rand_errcnt: got %0d want %0d", ec[0], errexp[0]); end
`endif
  endtask

  initial begin
    Reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      re[k] = 1'b0; we[k] = 1'b0; rw[k] = 2'd0; ww[k] = 2'd0; ad[k] = 32'd0; wd[k] = 32'd0;
      last_rd[k] = 32'd0; errexp[k] = 0;
    end
    #3;
    test_reset();
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    repeat (2) begin @(posedge Clock); #1; end
    test_word_roundtrip();
    test_lanes();
    test_misaligned();
    test_reset_mid();
    test_wrap_simul();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
